// File: rtl/mem_arb_pkg.sv
// Shared types for mem_req_arbiter: requester identity, lock FSM states and
// the response-routing tag kept per accepted transaction.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_t;

    // One entry per accepted-but-unanswered transaction. A set drop bit
    // means the response is consumed without being forwarded.
    typedef struct packed {
        arb_owner_t owner;
        logic       drop;
    } arb_tag_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO for mem_req_arbiter. Holds {owner, drop} for every
// accepted transaction; drop_inst marks all live fetch entries as discarded.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  arb_tag_t                   push_tag,
    input  logic                       pop,
    input  logic                       drop_inst,
    output arb_tag_t                   head_tag,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    arb_tag_t      mem [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_tag = mem[rd_ptr];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        // NOTE: every bit gets a value on every pass, so no latch is inferred.
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(i) - rd_ptr} < count_q);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage: write on push, mark live fetch entries on cancel.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale entries are invisible once count is zero.
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (wr_ptr == AW'(i))) begin
                mem[i] <= push_tag;
            end else if (drop_inst && entry_valid[i] && (mem[i].owner == OWN_INST)) begin
                mem[i].drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data requesters.
// Ownership is locked from first bus_req until address acceptance; responses
// come back in order and are routed through arb_tag_fifo.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration in IDLE;
// otherwise data has fixed priority over inst.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        arb_err
);

    localparam int CW = $clog2(OUTSTANDING) + 1;

    arb_state_t      state;
    arb_owner_t      win_owner;
    arb_owner_t      sel_owner;
    logic            sel_req;
    logic            at_capacity;
    logic            accept;
    logic            pop;
    logic            head_drop;
    arb_tag_t        push_tag;
    arb_tag_t        head_tag;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   tag_count;

`ifdef MEM_ARB_RR_EN
    arb_owner_t      last_owner;

    // Round-robin: with both requesting, the side that did not win last goes.
    always_comb begin
        if (inst_req && data_req) begin
            win_owner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else begin
            win_owner = data_req ? OWN_DATA : OWN_INST;
        end
    end

    // Remember the owner of the most recently accepted transaction.
    always_ff @(posedge clk) begin
        if (!resetn)     last_owner <= OWN_INST;
        else if (accept) last_owner <= sel_owner;
    end
`else
    // Fixed priority: data beats inst.
    always_comb begin
        win_owner = data_req ? OWN_DATA : OWN_INST;
    end
`endif

    // The lock overrides the idle-time winner until the address is accepted.
    always_comb begin
        case (state)
            LOCK_I:  sel_owner = OWN_INST;
            LOCK_D:  sel_owner = OWN_DATA;
            default: sel_owner = win_owner;
        endcase
        sel_req = (sel_owner == OWN_INST) ? inst_req : data_req;
    end

    assign at_capacity = (tag_count == CW'(OUTSTANDING));
    assign bus_req     = resetn && sel_req && !at_capacity;
    assign accept      = bus_req && bus_addr_ok;

    assign inst_addr_ok = accept && (sel_owner == OWN_INST);
    assign data_addr_ok = accept && (sel_owner == OWN_DATA);

    // Request mux toward the shared port; forced quiet while in reset.
    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (resetn) begin
            if (sel_owner == OWN_INST) begin
                bus_wr    = inst_wr;
                bus_size  = inst_size;
                bus_addr  = inst_addr;
                bus_wdata = inst_wdata;
            end else begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end
        end
    end

    // A fetch accepted alongside a cancel is born already discarded.
    always_comb begin
        push_tag.owner = sel_owner;
        push_tag.drop  = inst_cancel && (sel_owner == OWN_INST);
    end

    // Response routing: a cancel in the pop cycle still discards a fetch head.
    assign pop          = resetn && bus_data_ok && !fifo_empty;
    assign head_drop    = head_tag.drop || (inst_cancel && (head_tag.owner == OWN_INST));
    assign inst_data_ok = pop && (head_tag.owner == OWN_INST) && !head_drop;
    assign data_data_ok = pop && (head_tag.owner == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    arb_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept && !fifo_full),
        .push_tag  (push_tag),
        .pop       (pop),
        .drop_inst (inst_cancel),
        .head_tag  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (tag_count)
    );

    // Lock FSM: enter a lock when the winner is refused, leave on accept or
    // abandonment; frozen while the tag FIFO is at capacity.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (!at_capacity) begin
            case (state)
                IDLE: begin
                    if (bus_req && !bus_addr_ok) begin
                        state <= (win_owner == OWN_INST) ? LOCK_I : LOCK_D;
                    end
                end
                LOCK_I, LOCK_D: begin
                    if (accept || !sel_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flag for a response that has no matching tag.
    always_ff @(posedge clk) begin
        if (!resetn)                         arb_err <= 1'b0;
        else if (bus_data_ok && fifo_empty)  arb_err <= 1'b1;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter. Stimulus pushes the expected routed
// response into a scoreboard queue; a negedge monitor pops and compares
// whenever a *_data_ok is seen.
module tb_mem_req_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_cancel;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        arb_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_inst;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_req_arbiter #(.OUTSTANDING(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .inst_cancel  (inst_cancel),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .arb_err      (arb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every forwarded response must match the queue head.
    always @(negedge clk) begin
        if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp: inst_data_ok=%b data_data_ok=%b rdata=%h, none expected",
                         inst_data_ok, data_data_ok, bus_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, mon_e.is_inst});
                check("rsp_data_data_ok", {31'd0, data_data_ok}, {31'd0, !mon_e.is_inst});
                check("rsp_rdata", mon_e.is_inst ? inst_rdata : data_rdata, mon_e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2;
        bus_addr_ok = 0; bus_data_ok = 0;
    endtask

    // who: 0 = inst gets it, 1 = data gets it, 2 = silently dropped
    task automatic respond(input logic [31:0] rd, input int who);
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        if (who < 2) exp_q.push_back('{is_inst: (who == 0), rdata: rd});
    endtask

    task automatic accept_one(input bit is_inst, input logic [31:0] addr);
        inst_req = is_inst; data_req = !is_inst;
        if (is_inst) inst_addr = addr; else data_addr = addr;
        bus_addr_ok = 1'b1;
        #1;
        check(is_inst ? "acc_inst_addr_ok" : "acc_data_addr_ok",
              {31'd0, is_inst ? inst_addr_ok : data_addr_ok}, 32'd1);
        tick();
        inst_req = 0; data_req = 0; bus_addr_ok = 0;
    endtask

    initial begin
        clear_inputs();
        inst_addr = 0; inst_wdata = 0; data_addr = 0; data_wdata = 0;
        resetn = 1'b0;
        bus_rdata = 32'h55;
        tick();
        // Reset gating: requests and responses present but everything quiet.
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        inst_addr = 32'h1234;
        #1;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        check("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'h55);
        check("rst_data_rdata", data_rdata, 32'h55);
        tick();
        check("rst_arb_err", {31'd0, arb_err}, 32'd0);
        clear_inputs();
        resetn = 1'b1;
        tick();

        // Simultaneous requests: data wins first in both policies.
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wdata = 32'hDEAD;
        bus_addr_ok = 1;
        #1;
        check("t1_bus_addr", bus_addr, 32'h2000);
        check("t1_bus_wr", {31'd0, bus_wr}, 32'd1);
        check("t1_bus_wdata", bus_wdata, 32'hDEAD);
        check("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        clear_inputs();
        respond(32'hB0, 1);
        tick();
        clear_inputs();

        // Second simultaneous pair: round-robin hands it to inst.
        inst_req = 1; data_req = 1; bus_addr_ok = 1;
        #1;
        check("t1b_bus_addr", bus_addr, RR ? 32'h1000 : 32'h2000);
        check("t1b_inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, RR});
        tick();
        clear_inputs();
        respond(32'hC0, RR ? 0 : 1);
        tick();
        clear_inputs();

        // Lock: refused fetch keeps the bus even after data_req rises.
        inst_req = 1; inst_addr = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_locked_addr", bus_addr, 32'h3000);
            check("t2_no_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
            tick();
        end
        data_req = 1; data_addr = 32'h4000;
        #1;
        check("t2_lock_holds", bus_addr, 32'h3000);
        tick();
        bus_addr_ok = 1;
        #1;
        check("t2_inst_accept", {31'd0, inst_addr_ok}, 32'd1);
        check("t2_data_blocked", {31'd0, data_addr_ok}, 32'd0);
        check("t2_accept_addr", bus_addr, 32'h3000);
        tick();
        inst_req = 0;
        #1;
        check("t2_data_next", {31'd0, data_addr_ok}, 32'd1);
        check("t2_data_addr", bus_addr, 32'h4000);
        tick();
        clear_inputs();
        respond(32'h31, 0); tick();
        respond(32'h41, 1); tick();
        clear_inputs();

        // Capacity: four fetches fill the FIFO, the fifth waits for a pop.
        inst_req = 1; bus_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            inst_addr = 32'h5000 + 32'(4 * k);
            #1;
            check("t3_fill_ok", {31'd0, inst_addr_ok}, 32'd1);
            tick();
        end
        inst_addr = 32'h5010;
        #1;
        check("t3_full_bus_req", {31'd0, bus_req}, 32'd0);
        check("t3_full_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        respond(32'h11, 0);
        #1;
        check("t3_full_pop_bus_req", {31'd0, bus_req}, 32'd0);
        check("t3_full_pop_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        respond(32'h22, 0);
        #1;
        check("t3_fifth_accept", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 0; bus_addr_ok = 0;
        respond(32'h33, 0); tick();
        respond(32'h44, 0); tick();
        respond(32'h55, 0); tick();
        clear_inputs();
        check("t3_count_zero", 32'(dut.tag_count), 32'd0);

        // Mixed owners return in order.
        accept_one(1'b1, 32'h6000);
        accept_one(1'b0, 32'h6004);
        accept_one(1'b1, 32'h6008);
        respond(32'hA, 0); tick();
        respond(32'hB, 1); tick();
        respond(32'hC, 0); tick();
        clear_inputs();

        // Cancel drops both inflight fetches, keeps the data response.
        accept_one(1'b1, 32'h6100);
        accept_one(1'b0, 32'h6104);
        accept_one(1'b1, 32'h6108);
        inst_cancel = 1; tick(); inst_cancel = 0;
        respond(32'h1, 2); tick();
        respond(32'h2, 1); tick();
        respond(32'h3, 2); tick();
        clear_inputs();
        check("t5_count_zero", 32'(dut.tag_count), 32'd0);

        // Cancel coinciding with a head pop and a new fetch accept.
        accept_one(1'b1, 32'h7000);
        inst_cancel = 1;
        respond(32'h77, 2);
        inst_req = 1; inst_addr = 32'h7004; bus_addr_ok = 1;
        #1;
        check("t5b_accept", {31'd0, inst_addr_ok}, 32'd1);
        check("t5b_pop_dropped", {31'd0, inst_data_ok}, 32'd0);
        tick();
        clear_inputs();
        respond(32'h78, 2); tick();
        clear_inputs();
        check("t5b_count_zero", 32'(dut.tag_count), 32'd0);
        check("t5b_no_err", {31'd0, arb_err}, 32'd0);

        // Response with nothing outstanding raises a sticky error.
        respond(32'h99, 2);
        tick();
        clear_inputs();
        check("t6_err_set", {31'd0, arb_err}, 32'd1);
        tick(); tick();
        check("t6_err_sticky", {31'd0, arb_err}, 32'd1);

        // Reset in the middle of a lock.
        inst_req = 1; inst_addr = 32'h8000;
        tick();
        data_req = 1; data_addr = 32'h9000;
        #1;
        check("t7_locked", bus_addr, 32'h8000);
        resetn = 0;
        #1;
        check("t7_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("t7_rst_bus_addr", bus_addr, 32'd0);
        tick();
        resetn = 1;
        #1;
        check("t7_idle_after_rst", bus_addr, 32'h9000);
        check("t7_err_cleared", {31'd0, arb_err}, 32'd0);
        check("t7_count_cleared", 32'(dut.tag_count), 32'd0);
        clear_inputs();
        tick(); tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the data requester (the stage that asserts `data_req` and consumes `data_data_ok`/`data_rdata`). Requests are granted by priority with ownership locked until address acceptance. Responses return in order and are routed back by a tag FIFO. Inflight instruction responses can be cancelled on an exception or ERET redirect.

## Interface
- `OUTSTANDING`, 4: max accepted-but-unanswered transactions, power of two, 2..16.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_addr[31:0]`, `inst_wdata[31:0]`  in  fetch request; held stable until `inst_addr_ok`.
- `inst_addr_ok`  out  1  fetch request accepted this cycle.
- `inst_data_ok`  out  1  fetch response valid.
- `inst_rdata`  out  32  fetch read data.
- `inst_cancel`  in  1  discard responses of all currently inflight fetches.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wdata[31:0]`  in  data request; same hold rule.
- `data_addr_ok`, `data_data_ok`  out  1  data accept / response.
- `data_rdata`  out  32  data read data.
- `bus_req`, `bus_wr`, `bus_size[1:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]`  out  shared port request.
- `bus_addr_ok`, `bus_data_ok`  in  1  shared port accept / in-order response.
- `bus_rdata`  in  32  shared port read data.
- `arb_err`  out  1  sticky: `bus_data_ok` arrived with an empty tag FIFO.

## Operation
- Lock FSM: `IDLE`, `LOCK_I`, `LOCK_D`.
- In `IDLE`, the winner is chosen combinationally from `inst_req`/`data_req` (policy in Configuration). Its fields drive `bus_*` and `bus_req` in the same cycle.
- If the winner asserts `bus_req` and `bus_addr_ok`=0, the next state is `LOCK_<winner>`.
- In `LOCK_x`, only requester x drives the bus, regardless of the other request. Leave to `IDLE` on `bus_addr_ok`. If requester x drops its request, also return to `IDLE` (protocol violation, no error).
- `x_addr_ok` = `bus_addr_ok` && granted==x.
- Non-granted requester never sees `addr_ok`.
- On accept, push tag {owner, drop=0}.
- On `bus_data_ok`, pop the head. Route `bus_rdata` to the head's owner and pulse that `x_data_ok`, unless `drop`=1, in which case the response is silently consumed.
- Writes are tagged and answered like reads.
- `inst_cancel` sets `drop` on every queued inst-owned entry in the same cycle. A fetch accepted in the same cycle as `inst_cancel` is also pushed with `drop`=1.
- A head popped in the same cycle as `inst_cancel` is dropped: the cancel wins and `inst_data_ok` stays 0.
- `inst_cancel` never cancels an unaccepted lock. The fetch stage deasserts `inst_req` itself.

## Timing
- Request to bus: 0 cycles (combinational through the mux).
- Response to requester: 0 cycles (combinational `bus_data_ok` to `x_data_ok`; rdata is passed through).
- Full: when count==`OUTSTANDING`, force `bus_req`=0 and keep all `addr_ok` at 0, even if a pop occurs in the same cycle. The FSM state is held.
- Simultaneous push and pop: count is unchanged; the pointers advance.
- Empty with `bus_data_ok`: no pop, no `data_ok`, `arb_err` set until reset.
- Pointer wrap: modulo `OUTSTANDING`. Count width is clog2(`OUTSTANDING`)+1.
- Reset (mid-transaction included):
  - State `IDLE`, FIFO emptied, count 0, `arb_err` 0.
  - All `bus_*`, `*_addr_ok`, `*_data_ok` at 0.
  - `*_rdata` follows `bus_rdata`.
  - The bus must also be reset.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin in `IDLE`. A 1-bit `last` register flips to the other requester after each accepted transaction. With both requesting, the one not equal to `last` wins. `last` resets to inst, so data wins first.
- Undefined: fixed priority, data over inst. The `last` register is not built.

## Structure
- Package `mem_arb_pkg`:
  - `arb_owner_t` (`OWN_INST`, `OWN_DATA`).
  - `arb_state_t` (`IDLE`, `LOCK_I`, `LOCK_D`).
  - Tag struct {owner, drop}.
- Sub-module `arb_tag_fifo`:
  - Parameterised depth.
  - push/pop/full/empty/count interface.
  - Plus a `drop_inst` input that sets `drop` on all valid entries whose owner is `OWN_INST`.
- The top contains the FSM, mux, priority logic, and error flag.

## Test plan
- Both request in the same cycle, `bus_addr_ok`=1: data granted (fixed) and `data_addr_ok`=1. With RR, the next simultaneous pair grants inst.
- Inst requests, `bus_addr_ok`=0 for 3 cycles, then `data_req` rises: `bus_addr` stays equal to `inst_addr` until accept. Data is granted the following cycle.
- Issue 4 fetches with `OUTSTANDING`=4, then a fifth: `bus_req`=0 until the first `bus_data_ok`. Responses 0x11, 0x22… arrive on `inst_rdata` in order.
- Mixed I,D,I accepted; responses 0xA,0xB,0xC: `inst_data_ok` with 0xA, `data_data_ok` with 0xB, `inst_data_ok` with 0xC.
- I,D,I inflight, `inst_cancel` pulse, three responses: only `data_data_ok` fires. The count returns to 0.
- `bus_data_ok` with an empty FIFO: `arb_err`=1 and stays set. Reset mid-lock clears the state and `bus_req`.
